uart_rx_engine: RTL and testbench

Parametrised UART receive engine; the next-generation receive path for `uart_top`. It adds run-time selection of data length, parity enable and sense, and one or two stop bits, plus a clock-frequency-generic baud table. It also provides majority-voted mid-bit sampling and framing, parity and overrun status. It sits between the `rx` pin and the host read interface.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_rx_engine.sv | 113 +++++++++++
 tb/tb_uart_rx_engine.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receive FSM states, latched frame config and baud-rate table
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_e;
  typedef struct packed {
    logic eight;
    logic pen;
    logic ohel;
    logic stop2;
  } rx_cfg_t;
  localparam int unsigned BAUD_RATES [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400,
                                              57600, 115200, 230400, 460800, 921600};
  // Loop over constant indices so each division folds to a constant and the result is a mux.
  function automatic int unsigned bit_time(input int unsigned clk_hz, input logic [3:0] sel);
    bit_time = clk_hz / 9600;
    for (int i = 0; i < 12; i++)
      if (sel == 4'(i)) bit_time = clk_hz / BAUD_RATES[i];
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-time counter issuing a registered sample strobe at HB-1 or BT-1
module uart_bit_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             half,
  input  logic [CNT_W-1:0] bt,
  output logic             sample
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             hit;
  assign term = half ? (bt >> 1) - CNT_W'(1) : bt - CNT_W'(1);
  assign hit  = cnt == term;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt    <= '0;
      sample <= 1'b0;
    end else begin
      cnt    <= hit ? '0 : cnt + CNT_W'(1);
      sample <= hit;
    end
  end
endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: configurable UART receiver with majority-voted sampling and status flags
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       stop2,
  input  logic [3:0] baud,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);
  rx_state_e        state, state_n;
  rx_cfg_t          cfg;
  logic [1:0]       sync;
  logic [2:0]       hist;
  logic [CNT_W-1:0] bt;
  logic [7:0]       sh;
  logic [7:0]       word;
  logic [2:0]       bcnt;
  logic             bit_v, sample, start, done, pe, fe, wait_hi;
  assign bit_v = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
  assign word  = cfg.eight ? sh : {1'b0, sh[7:1]};
  assign busy  = state != IDLE;
  assign start = state == IDLE && state_n == START;
  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .half   (state == START),
    .bt     (bt),
    .sample (sample)
  );
  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:   state_n = (!wait_hi && !sync[1]) ? START : IDLE;
      START:  if (sample) state_n = bit_v ? IDLE : DATA;
      DATA:   if (sample && bcnt == {2'b11, cfg.eight}) state_n = cfg.pen ? PARITY : STOP1;
      PARITY: if (sample) state_n = STOP1;
      STOP1:  if (sample) begin
        state_n = cfg.stop2 ? STOP2 : IDLE;
        done    = !cfg.stop2;
      end
      STOP2:  if (sample) begin
        state_n = IDLE;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sync    <= 2'b11;
      hist    <= 3'b111;
      cfg     <= '0;
      bt      <= '0;
      sh      <= '0;
      bcnt    <= '0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      wait_hi <= 1'b0;
      data    <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_n;
      sync  <= {sync[0], rx};
      hist  <= {hist[1:0], sync[1]};
      if (start) begin
        cfg  <= '{eight: eight, pen: pen, ohel: ohel, stop2: stop2};
        bt   <= CNT_W'(bit_time(CLK_HZ, baud));
        bcnt <= '0;
        pe   <= 1'b0;
        fe   <= 1'b0;
      end
      if (state == DATA && sample) begin
        sh   <= {bit_v, sh[7:1]};
        bcnt <= bcnt + 3'd1;
      end
      if (state == PARITY && sample) pe <= bit_v != (^word ^ cfg.ohel);
      if (state == STOP1 && sample) fe <= !bit_v;
      // A low final stop bit may be a break: hold off start detection until the line idles high.
      if (done) wait_hi <= !bit_v;
      else if (state == IDLE && sync[1]) wait_hi <= 1'b0;
      if (done) begin
        data  <= word;
        perr  <= pe;
        ferr  <= fe | !bit_v;
        rxrdy <= 1'b1;
        ovf   <= rxrdy & !rd_ack;
      end else if (rd_ack) begin
        rxrdy <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed frames at BT=160 with hand-computed expectations
module tb_uart_rx_engine;
  logic       clk = 1'b0;
  logic       reset, rx, eight, pen, ohel, stop2, rd_ack;
  logic [3:0] baud;
  logic [7:0] data;
  logic       rxrdy, perr, ferr, ovf, busy;
  int         checks = 0, errors = 0;
  int         cyc = 0, fall_cyc = 0, busy_cyc = 0, rdy_cyc = 0;
  logic       busy_q = 1'b0, rdy_q = 1'b0;
  uart_rx_engine #(.CLK_HZ(1_536_000), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .rx(rx), .eight(eight), .pen(pen), .ohel(ohel),
    .stop2(stop2), .baud(baud), .rd_ack(rd_ack), .data(data), .rxrdy(rxrdy),
    .perr(perr), .ferr(ferr), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    busy_q <= busy;
    rdy_q  <= rxrdy;
    if (busy && !busy_q) busy_cyc <= cyc;
    if (rxrdy && !rdy_q) rdy_cyc <= cyc;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input int n, input logic pb_en, input logic pb,
                      input logic s1, input int ns, input int gbit, input logic ack_done,
                      input logic flip);
    rx = 1'b0;
    fall_cyc = cyc;
    tick(160);
    if (flip) eight = !eight;
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      if (i == gbit) begin
        tick(81);
        rx = !d[i];
        tick(1);
        rx = d[i];
        tick(78);
      end else tick(160);
    end
    if (pb_en) begin
      rx = pb;
      tick(160);
    end
    rx = s1;
    if (ack_done) begin
      tick(83);
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      tick(76);
    end else tick(160);
    if (ns == 2) begin
      rx = 1'b1;
      tick(160);
    end
    rx = 1'b1;
    tick(20);
  endtask
  initial begin
    reset = 1'b1; rx = 1'b1; rd_ack = 1'b0;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; stop2 = 1'b0; baud = 4'd4;
    tick(4);
    reset = 1'b0;
    tick(2);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_rxrdy", 32'(rxrdy), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    chk("8n1_data", 32'(data), 32'hA5);
    chk("8n1_rxrdy", 32'(rxrdy), 1);
    chk("8n1_perr", 32'(perr), 0);
    chk("8n1_ferr", 32'(ferr), 0);
    chk("8n1_busy", 32'(busy), 0);
    chk("start_latency", 32'(busy_cyc - fall_cyc), 3);
    chk("8n1_rdy_latency", 32'(rdy_cyc - busy_cyc), 1521);
    ack();
    chk("ack_rxrdy", 32'(rxrdy), 0);
    chk("ack_data_hold", 32'(data), 32'hA5);
    eight = 1'b0; pen = 1'b1; ohel = 1'b1; stop2 = 1'b1;
    send(8'h41, 7, 1'b1, 1'b1, 1'b1, 2, -1, 1'b0, 1'b0);
    chk("7o2_good_data", 32'(data), 32'h41);
    chk("7o2_good_perr", 32'(perr), 0);
    chk("7o2_good_ferr", 32'(ferr), 0);
    chk("7o2_rdy_latency", 32'(rdy_cyc - busy_cyc), 1681);
    ack();
    send(8'h41, 7, 1'b1, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0);
    chk("7o2_bad_data", 32'(data), 32'h41);
    chk("7o2_bad_perr", 32'(perr), 1);
    ack();
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; stop2 = 1'b0;
    send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, 1'b0);
    chk("ferr_data", 32'(data), 32'h5A);
    chk("ferr_flag", 32'(ferr), 1);
    ack();
    rx = 1'b0;
    tick(20 * 160);
    chk("break_data", 32'(data), 32'h00);
    chk("break_ferr", 32'(ferr), 1);
    chk("break_rxrdy", 32'(rxrdy), 1);
    ack();
    tick(800);
    chk("break_hold_rxrdy", 32'(rxrdy), 0);
    chk("break_hold_busy", 32'(busy), 0);
    rx = 1'b1;
    tick(50);
    rx = 1'b0;
    tick(60);
    chk("false_start_busy", 32'(busy), 1);
    rx = 1'b1;
    tick(200);
    chk("false_start_idle", 32'(busy), 0);
    chk("false_start_rxrdy", 32'(rxrdy), 0);
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0);
    chk("glitch_data", 32'(data), 32'hA5);
    chk("glitch_ferr", 32'(ferr), 0);
    ack();
    send(8'h11, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    chk("ovf_first_clear", 32'(ovf), 0);
    send(8'h22, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    chk("ovf_data", 32'(data), 32'h22);
    chk("ovf_flag", 32'(ovf), 1);
    ack();
    chk("ovf_ack_rxrdy", 32'(rxrdy), 0);
    chk("ovf_ack_ovf", 32'(ovf), 0);
    send(8'h33, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    send(8'h44, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b1, 1'b0);
    chk("ack_on_done_data", 32'(data), 32'h44);
    chk("ack_on_done_rxrdy", 32'(rxrdy), 1);
    chk("ack_on_done_ovf", 32'(ovf), 0);
    rx = 1'b0;
    tick(480);
    chk("mid_data_busy", 32'(busy), 1);
    reset = 1'b1;
    tick(1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rxrdy", 32'(rxrdy), 0);
    chk("reset_data", 32'(data), 32'h00);
    reset = 1'b0;
    rx = 1'b1;
    tick(200);
    pen = 1'b1;
    send(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    chk("8e1_data", 32'(data), 32'h3C);
    chk("8e1_perr", 32'(perr), 0);
    chk("8e1_ferr", 32'(ferr), 0);
    ack();
    pen = 1'b0;
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b1);
    chk("cfg_latch_data", 32'(data), 32'hC3);
    chk("cfg_latch_ferr", 32'(ferr), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
